// File: rtl/tdp_ram_pkg.sv
// Shared definitions for the byte-enable true dual-port RAM: read-mode codes,
// clear FSM states and the lane-count helper.
package tdp_ram_pkg;

    localparam int unsigned RD_READ_FIRST  = 0;
    localparam int unsigned RD_WRITE_FIRST = 1;
    localparam int unsigned RD_NO_CHANGE   = 2;

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StReady
    } state_e;

    function automatic int unsigned nb_calc(input int unsigned data_width,
                                            input int unsigned byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/tdp_ram_be_if.sv
// One RAM access port: request fields driven by the master, read data and
// valid returned by the RAM.
interface tdp_ram_be_if
    import tdp_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned BYTE_WIDTH = 8
);
    localparam int unsigned NB = nb_calc(DATA_WIDTH, BYTE_WIDTH);

    logic                  en;
    logic [NB-1:0]         we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_vld;

    modport master (output en, output we, output addr, output din,
                    input dout, input dout_vld);
    modport slave  (input en, input we, input addr, input din,
                    output dout, output dout_vld);

endinterface

// File: rtl/tdp_ram_port.sv
// Per-port read path: byte merge, read-during-write selection, optional
// output register and valid pipeline.
module tdp_ram_port
    import tdp_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned RD_MODE    = 0,
    parameter int unsigned OUT_REG    = 0,
    localparam int unsigned NB        = nb_calc(DATA_WIDTH, BYTE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  acc_i,
    input  logic [NB-1:0]         we_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic [DATA_WIDTH-1:0] old_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  vld_o
);

    logic                  wr;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] dout1_d, dout1_q;
    logic                  vld1_d, vld1_q;

    assign wr = |we_i;

    always_comb begin
        merged = old_i;
        for (int i = 0; i < int'(NB); i++) begin
            if (we_i[i]) merged[i*BYTE_WIDTH +: BYTE_WIDTH] = din_i[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    always_comb begin
        dout1_d = old_i;
        vld1_d  = acc_i;
        if (wr && RD_MODE == RD_WRITE_FIRST) dout1_d = merged;
        if (wr && RD_MODE == RD_NO_CHANGE) vld1_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout1_q <= '0;
            vld1_q  <= 1'b0;
        end else begin
            vld1_q <= vld1_d;
            if (vld1_d) dout1_q <= dout1_d;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] dout2_q;
        logic                  vld2_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout2_q <= '0;
                vld2_q  <= 1'b0;
            end else begin
                vld2_q <= vld1_q;
                if (vld1_q) dout2_q <= dout1_q;
            end
        end

        assign dout_o = dout2_q;
        assign vld_o  = vld2_q;
    end else begin : g_no_out_reg
        assign dout_o = dout1_q;
        assign vld_o  = vld1_q;
    end

endmodule

// File: rtl/tdp_ram_be.sv
// Single-clock true dual-port RAM with byte enables, post-reset clear and
// deterministic same-address arbitration (port A wins overlapping lanes).
module tdp_ram_be
    import tdp_ram_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           ADDR_WIDTH   = 10,
    parameter int unsigned           BYTE_WIDTH   = 8,
    parameter int unsigned           RD_MODE      = 0,
    parameter int unsigned           OUT_REG      = 0,
    parameter int unsigned           CLEAR_ON_RST = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        init_done_o,
    output logic        collision_o,
    tdp_ram_be_if.slave port_a,
    tdp_ram_be_if.slave port_b
);

    localparam int unsigned NB    = nb_calc(DATA_WIDTH, BYTE_WIDTH);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  init_done_q, init_done_d;
    logic                  collision_q, collision_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  acc_a, acc_b, same_addr;
    logic [NB-1:0]         wr_a, wr_b;

    assign acc_a     = port_a.en & init_done_q;
    assign acc_b     = port_b.en & init_done_q;
    assign same_addr = acc_a & acc_b & (port_a.addr == port_b.addr);
    assign wr_a      = acc_a ? port_a.we : '0;
    // B loses any lane A also writes at the same address.
    assign wr_b      = (acc_b ? port_b.we : '0) & ~(same_addr ? wr_a : '0);

    assign collision_d = same_addr & ((|port_a.we) | (|port_b.we));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                cnt_d   = '0;
                state_d = (CLEAR_ON_RST != 0) ? StClear : StReady;
            end
            StClear: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) state_d = StReady;
            end
            StReady: state_d = StReady;
            default: state_d = StIdle;
        endcase
    end

    assign init_done_d = (state_d == StReady);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            init_done_q <= (CLEAR_ON_RST == 0);
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            collision_q <= collision_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            mem_q[cnt_q] <= CLEAR_VALUE;
        end else begin
            for (int i = 0; i < int'(NB); i++) begin
                if (wr_a[i]) begin
                    mem_q[port_a.addr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                        port_a.din[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
                if (wr_b[i]) begin
                    mem_q[port_b.addr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                        port_b.din[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    tdp_ram_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .BYTE_WIDTH(BYTE_WIDTH),
        .RD_MODE   (RD_MODE),
        .OUT_REG   (OUT_REG)
    ) u_port_a (
        .clk   (clk),
        .rst   (rst),
        .acc_i (acc_a),
        .we_i  (port_a.we),
        .din_i (port_a.din),
        .old_i (mem_q[port_a.addr]),
        .dout_o(port_a.dout),
        .vld_o (port_a.dout_vld)
    );

    tdp_ram_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .BYTE_WIDTH(BYTE_WIDTH),
        .RD_MODE   (RD_MODE),
        .OUT_REG   (OUT_REG)
    ) u_port_b (
        .clk   (clk),
        .rst   (rst),
        .acc_i (acc_b),
        .we_i  (port_b.we),
        .din_i (port_b.din),
        .old_i (mem_q[port_b.addr]),
        .dout_o(port_b.dout),
        .vld_o (port_b.dout_vld)
    );

    assign init_done_o = init_done_q;
    assign collision_o = collision_q;

endmodule
